instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the simple processor datapath.
- Fetches 12-bit instructions from a synchronous instruction memory, or accepts one from the switches.
- Drives register-file, ALU and data-memory controls in fixed 4-cycle slots, so that loads and stores meet memory read latency.
- Supports single-step, free-run and halt.

Parameters:
- IM_AW, 4, instruction-memory address width; PC width, wraps modulo 2^IM_AW.
- CNT_W, 8, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run_mode  in  1  1 = free-run; 0 = single-step.
- step_pulse  in  1  one-cycle debounced pulse; starts one fetched instruction.
- ext_pulse  in  1  one-cycle debounced pulse; executes ext_instr.
- ext_instr  in  12  switch instruction.
- im_data  in  12  instruction memory read data; valid one cycle after im_addr.
- im_addr  out  IM_AW  equals PC.
- d_rd  out  1  data-memory read strobe.
- d_wr  out  1  data-memory write strobe.
- d_addr  out  4  data-memory address.
- is_ext  out  1  RF write-data mux: 1 = memory, 0 = ALU.
- alu_sel  out  2  ALU op: 00 pass, 01 add, 10 sub.
- rf_we  out  1  RF write enable.
- rf_raddr1, rf_raddr2, rf_waddr  out  3 each  RF addresses.
- busy  out  1  state not IDLE and not HALTED.
- halted  out  1  in HALTED state.
- retired  out  CNT_W  count of completed instructions; wraps.

Behaviour:
- Reset (reset=0, async): state IDLE, PC=0, IR=0, retired=0, every output 0. Applies immediately, including mid-instruction; no strobe survives reset.
- Encoding, opcode = IR[11:9]:
  - 000 LOAD: RF[IR[6:4]] <= D[IR[3:0]].
  - 001 STORE: D[IR[3:0]] <= RF[IR[6:4]].
  - 101 ADD: RF[IR[8:6]] <= RF[IR[2:0]] + RF[IR[5:3]].
  - 110 SUB: same operands as ADD, subtract.
  - 111 HALT.
  - 010, 011, 100 NOP.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALTED. Controls are a registered function of next state/IR; no output is combinational from inputs.
- IDLE transitions, in priority order:
  - ext_pulse: IR <= ext_instr, go to EXEC. PC unchanged.
  - step_pulse, or run_mode=1: go to FETCH.
- FETCH: im_addr=PC held. Go to DECODE.
- DECODE: IR <= im_data, PC <= PC+1 (wraps). Go to EXEC.
- EXEC, 1 cycle:
  - LOAD: d_rd=1, d_addr=IR[3:0].
  - STORE: rf_raddr1=IR[6:4], d_addr=IR[3:0].
  - ADD/SUB: rf_raddr1=IR[2:0], rf_raddr2=IR[5:3], alu_sel=01 or 10.
  - NOP: no strobes.
  - HALT: go to HALTED; retired increments.
- WB, 1 cycle; all EXEC addresses and alu_sel held:
  - LOAD: d_rd=1, is_ext=1, rf_we=1, rf_waddr=IR[6:4].
  - STORE: d_wr=1.
  - ADD/SUB: rf_we=1, rf_waddr=IR[8:6].
  - On exit, retired += 1.
- After WB: if run_mode=1 go to FETCH (back-to-back, 4 cycles/instruction); otherwise go to IDLE.
- Strobes d_rd, d_wr, rf_we deassert in every cycle outside the slots listed above. d_wr and rf_we are high for exactly one cycle per instruction. Address outputs keep their last value when idle.
- HALTED: no strobes; halted=1. Exits only on step_pulse or ext_pulse (handled as in IDLE), or reset. Execution resumes at PC (the address after the HALT).
- step_pulse and ext_pulse outside IDLE/HALTED are ignored and are not queued.
- Simultaneous ext_pulse and step_pulse: ext wins; step is dropped.
- run_mode falling mid-instruction: the current instruction completes, then IDLE.
- PC wraps from 2^IM_AW-1 to 0 without a flag. retired wraps at 2^CNT_W.
- Undefined opcodes are NOPs: they still consume 4 cycles and count as retired.

Test Plan:
- Reset: drive reset=0 mid-run -> all outputs 0 in the same cycle, PC=0, retired=0. Release -> IDLE, busy=0.
- ext LOAD: ext_instr=12'h035, ext_pulse -> EXEC: d_rd=1, d_addr=5. WB: rf_we=1, rf_waddr=3, is_ext=1. PC stays 0; retired=1; then IDLE.
- Step ADD: IM[0]=12'hA88, step_pulse -> im_addr=0. EXEC: rf_raddr1=0, rf_raddr2=1, alu_sel=01. WB: rf_we=1, rf_waddr=2. PC=1. A second step_pulse during EXEC is ignored.
- Run program at addr 0:
  - Program: IM={12'h215 STORE, 12'hC50 SUB, 12'hE00 HALT}; run_mode=1.
  - Expect d_wr high exactly 1 cycle with d_addr=5, rf_raddr1=1.
  - SUB WB: rf_waddr=1, alu_sel=10.
  - Then halted=1, PC=3, retired=3, busy=0. Total 12 cycles from first FETCH.
- Wrap: IM all NOP (12'h400), run for 17 instructions -> PC goes 15 to 0 then 1; retired=17; no strobes ever asserted.
- Reset during LOAD WB (rf_we=1) -> rf_we and d_rd drop immediately; after release, state IDLE, no write completes.

Source files
------------

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle fetch/decode/execute sequencer. Fetches 12-bit
//               instructions from a synchronous instruction memory (or takes
//               one from the switches) and drives register-file, ALU and
//               data-memory controls in fixed FETCH/DECODE/EXEC/WB slots.
//               Supports single-step, free-run and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int IM_AW = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_mode,
    input  logic             step_pulse,
    input  logic             ext_pulse,
    input  logic [11:0]      ext_instr,
    input  logic [11:0]      im_data,
    output logic [IM_AW-1:0] im_addr,
    output logic             d_rd,
    output logic             d_wr,
    output logic [3:0]       d_addr,
    output logic             is_ext,
    output logic [1:0]       alu_sel,
    output logic             rf_we,
    output logic [2:0]       rf_raddr1,
    output logic [2:0]       rf_raddr2,
    output logic [2:0]       rf_waddr,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] c_OP_LOAD  = 3'b000;
    localparam logic [2:0] c_OP_STORE = 3'b001;
    localparam logic [2:0] c_OP_ADD   = 3'b101;
    localparam logic [2:0] c_OP_SUB   = 3'b110;
    localparam logic [2:0] c_OP_HALT  = 3'b111;

    localparam logic [1:0] c_ALU_PASS = 2'b00;
    localparam logic [1:0] c_ALU_ADD  = 2'b01;
    localparam logic [1:0] c_ALU_SUB  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IM_AW-1:0]   r_pc;
    logic [IM_AW-1:0]   w_pc_nxt;
    logic [11:0]        r_ir;
    logic [11:0]        w_ir_nxt;
    logic [CNT_W-1:0]   w_retired_nxt;

    logic               w_d_rd_nxt;
    logic               w_d_wr_nxt;
    logic [3:0]         w_d_addr_nxt;
    logic               w_is_ext_nxt;
    logic [1:0]         w_alu_sel_nxt;
    logic               w_rf_we_nxt;
    logic [2:0]         w_rf_raddr1_nxt;
    logic [2:0]         w_rf_raddr2_nxt;
    logic [2:0]         w_rf_waddr_nxt;
    logic               w_busy_nxt;
    logic               w_halted_nxt;
    logic [2:0]         w_op_nxt;
    logic               w_in_slot;
    logic               w_in_wb;

    // The memory address is simply the program counter.
    assign im_addr = r_pc;

    // Next-state, IR, PC and retired-count logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_ir_nxt      = r_ir;
        w_pc_nxt      = r_pc;
        w_retired_nxt = retired;
        case (r_state)
            S_IDLE, S_HALTED: begin
                // Switch instruction has priority; a simultaneous step is dropped.
                if (ext_pulse) begin
                    w_ir_nxt    = ext_instr;
                    w_state_nxt = S_EXEC;
                end else if (step_pulse || (r_state == S_IDLE && run_mode)) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                // im_data now holds the word addressed during FETCH.
                w_ir_nxt    = im_data;
                w_pc_nxt    = r_pc + 1'b1;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (r_ir[11:9] == c_OP_HALT) begin
                    w_state_nxt   = S_HALTED;
                    w_retired_nxt = retired + 1'b1;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB: begin
                w_retired_nxt = retired + 1'b1;
                w_state_nxt   = run_mode ? S_FETCH : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control outputs for the upcoming cycle, decoded from next state and next IR.
    always_comb begin
        w_op_nxt        = w_ir_nxt[11:9];
        w_in_slot       = (w_state_nxt == S_EXEC) || (w_state_nxt == S_WB);
        w_in_wb         = (w_state_nxt == S_WB);
        w_d_rd_nxt      = 1'b0;
        w_d_wr_nxt      = 1'b0;
        w_is_ext_nxt    = 1'b0;
        w_rf_we_nxt     = 1'b0;
        w_d_addr_nxt    = d_addr;
        w_alu_sel_nxt   = alu_sel;
        w_rf_raddr1_nxt = rf_raddr1;
        w_rf_raddr2_nxt = rf_raddr2;
        w_rf_waddr_nxt  = rf_waddr;
        w_busy_nxt      = (w_state_nxt != S_IDLE) && (w_state_nxt != S_HALTED);
        w_halted_nxt    = (w_state_nxt == S_HALTED);
        if (w_in_slot) begin
            case (w_op_nxt)
                c_OP_LOAD: begin
                    // Read strobe spans EXEC and WB to cover memory read latency.
                    w_d_rd_nxt    = 1'b1;
                    w_d_addr_nxt  = w_ir_nxt[3:0];
                    w_alu_sel_nxt = c_ALU_PASS;
                    if (w_in_wb) begin
                        w_is_ext_nxt   = 1'b1;
                        w_rf_we_nxt    = 1'b1;
                        w_rf_waddr_nxt = w_ir_nxt[6:4];
                    end
                end
                c_OP_STORE: begin
                    w_rf_raddr1_nxt = w_ir_nxt[6:4];
                    w_d_addr_nxt    = w_ir_nxt[3:0];
                    w_alu_sel_nxt   = c_ALU_PASS;
                    w_d_wr_nxt      = w_in_wb;
                end
                c_OP_ADD, c_OP_SUB: begin
                    w_rf_raddr1_nxt = w_ir_nxt[2:0];
                    w_rf_raddr2_nxt = w_ir_nxt[5:3];
                    w_alu_sel_nxt   = (w_op_nxt == c_OP_ADD) ? c_ALU_ADD : c_ALU_SUB;
                    if (w_in_wb) begin
                        w_rf_we_nxt    = 1'b1;
                        w_rf_waddr_nxt = w_ir_nxt[8:6];
                    end
                end
                default: begin
                    // NOP, HALT and undefined opcodes drive no strobes.
                end
            endcase
        end
    end

    // State, datapath registers and registered control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            retired   <= '0;
            d_rd      <= 1'b0;
            d_wr      <= 1'b0;
            d_addr    <= '0;
            is_ext    <= 1'b0;
            alu_sel   <= '0;
            rf_we     <= 1'b0;
            rf_raddr1 <= '0;
            rf_raddr2 <= '0;
            rf_waddr  <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_ir      <= w_ir_nxt;
            retired   <= w_retired_nxt;
            d_rd      <= w_d_rd_nxt;
            d_wr      <= w_d_wr_nxt;
            d_addr    <= w_d_addr_nxt;
            is_ext    <= w_is_ext_nxt;
            alu_sel   <= w_alu_sel_nxt;
            rf_we     <= w_rf_we_nxt;
            rf_raddr1 <= w_rf_raddr1_nxt;
            rf_raddr2 <= w_rf_raddr2_nxt;
            rf_waddr  <= w_rf_waddr_nxt;
            busy      <= w_busy_nxt;
            halted    <= w_halted_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Directed self-checking bench for instr_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_mode;
    logic        step_pulse;
    logic        ext_pulse;
    logic [11:0] ext_instr;
    logic [11:0] im_data;
    logic [3:0]  im_addr;
    logic        d_rd;
    logic        d_wr;
    logic [3:0]  d_addr;
    logic        is_ext;
    logic [1:0]  alu_sel;
    logic        rf_we;
    logic [2:0]  rf_raddr1;
    logic [2:0]  rf_raddr2;
    logic [2:0]  rf_waddr;
    logic        busy;
    logic        halted;
    logic [7:0]  retired;

    logic [11:0] imem [16];

    int n_checks = 0;
    int n_fail   = 0;

    instr_sequencer #(.IM_AW(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .run_mode   (run_mode),
        .step_pulse (step_pulse),
        .ext_pulse  (ext_pulse),
        .ext_instr  (ext_instr),
        .im_data    (im_data),
        .im_addr    (im_addr),
        .d_rd       (d_rd),
        .d_wr       (d_wr),
        .d_addr     (d_addr),
        .is_ext     (is_ext),
        .alu_sel    (alu_sel),
        .rf_we      (rf_we),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_waddr   (rf_waddr),
        .busy       (busy),
        .halted     (halted),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid one cycle after the address.
    always @(posedge clk) im_data <= imem[im_addr];

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int   wr_cnt;
        int   halt_cyc;
        int   strobes;
        bit   sub_seen;
        bit   wrapped;
        bit   done;
        logic [3:0] prev_addr;

        for (int i = 0; i < 16; i++) imem[i] = 12'h400;
        reset = 1'b0; run_mode = 1'b0; step_pulse = 1'b0; ext_pulse = 1'b0;
        ext_instr = 12'h000;
        tick; tick;

        // Reset state
        check("rst_outs", 32'({d_rd, d_wr, d_addr, is_ext, alu_sel, rf_we, rf_raddr1,
                               rf_raddr2, rf_waddr, busy, halted}), 0);
        check("rst_pc", 32'(im_addr), 0);
        check("rst_retired", 32'(retired), 0);
        reset = 1'b1;
        tick;
        check("idle_busy", 32'(busy), 0);

        // Switch LOAD 12'h035: RF[3] <= D[5]
        ext_instr = 12'h035; ext_pulse = 1'b1;
        tick; ext_pulse = 1'b0;
        check("ld_exec_drd", 32'(d_rd), 1);
        check("ld_exec_daddr", 32'(d_addr), 5);
        check("ld_exec_rfwe", 32'(rf_we), 0);
        check("ld_exec_busy", 32'(busy), 1);
        tick;
        check("ld_wb_rfwe", 32'(rf_we), 1);
        check("ld_wb_waddr", 32'(rf_waddr), 3);
        check("ld_wb_isext", 32'(is_ext), 1);
        check("ld_wb_drd", 32'(d_rd), 1);
        check("ld_wb_dwr", 32'(d_wr), 0);
        tick;
        check("ld_done_busy", 32'(busy), 0);
        check("ld_done_strb", 32'({d_rd, rf_we}), 0);
        check("ld_done_ret", 32'(retired), 1);
        check("ld_done_pc", 32'(im_addr), 0);
        check("ld_done_daddr", 32'(d_addr), 5);

        // Single-step ADD 12'hA88: RF[2] <= RF[0] + RF[1]
        imem[0] = 12'hA88;
        step_pulse = 1'b1;
        tick; step_pulse = 1'b0;
        check("add_fetch_pc", 32'(im_addr), 0);
        check("add_fetch_busy", 32'(busy), 1);
        tick;
        tick;
        check("add_exec_ra1", 32'(rf_raddr1), 0);
        check("add_exec_ra2", 32'(rf_raddr2), 1);
        check("add_exec_alu", 32'(alu_sel), 1);
        check("add_exec_rfwe", 32'(rf_we), 0);
        check("add_exec_pc", 32'(im_addr), 1);
        step_pulse = 1'b1;
        tick; step_pulse = 1'b0;
        check("add_wb_rfwe", 32'(rf_we), 1);
        check("add_wb_waddr", 32'(rf_waddr), 2);
        check("add_wb_alu", 32'(alu_sel), 1);
        tick;
        check("add_done_busy", 32'(busy), 0);
        check("add_done_ret", 32'(retired), 2);
        tick;
        check("step_not_queued", 32'(busy), 0);

        // Reset asserted during LOAD write-back
        ext_instr = 12'h035; ext_pulse = 1'b1;
        tick; ext_pulse = 1'b0;
        tick;
        check("rstwb_pre_rfwe", 32'(rf_we), 1);
        #2 reset = 1'b0;
        #1;
        check("rstwb_rfwe", 32'(rf_we), 0);
        check("rstwb_drd", 32'(d_rd), 0);
        check("rstwb_isext", 32'(is_ext), 0);
        check("rstwb_ret", 32'(retired), 0);
        check("rstwb_pc", 32'(im_addr), 0);
        tick; tick;
        reset = 1'b1;
        tick;
        check("rstwb_idle", 32'({busy, halted, rf_we, d_rd}), 0);
        check("rstwb_noretire", 32'(retired), 0);

        // Free-run program: STORE, SUB, HALT
        imem[0] = 12'h215; imem[1] = 12'hC50; imem[2] = 12'hE00;
        run_mode = 1'b1;
        wr_cnt = 0; halt_cyc = 0; sub_seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (d_wr) begin
                wr_cnt++;
                check("st_daddr", 32'(d_addr), 5);
                check("st_ra1", 32'(rf_raddr1), 1);
            end
            if (rf_we) begin
                sub_seen = 1'b1;
                check("sub_waddr", 32'(rf_waddr), 1);
                check("sub_alu", 32'(alu_sel), 2);
            end
            if (halted) begin
                halt_cyc = i;
                break;
            end
        end
        run_mode = 1'b0;
        check("prog_dwr_cycles", 32'(wr_cnt), 1);
        check("prog_sub_seen", 32'(sub_seen), 1);
        check("prog_halt_cycle", 32'(halt_cyc), 12);
        check("prog_halted", 32'(halted), 1);
        check("prog_pc", 32'(im_addr), 3);
        check("prog_ret", 32'(retired), 3);
        check("prog_busy", 32'(busy), 0);

        // Leaving HALTED with ext and step together: ext NOP wins
        ext_instr = 12'h400; ext_pulse = 1'b1; step_pulse = 1'b1;
        tick; ext_pulse = 1'b0; step_pulse = 1'b0;
        check("prio_unhalt", 32'({halted, busy}), 1);
        tick; tick;
        check("prio_busy", 32'(busy), 0);
        check("prio_ret", 32'(retired), 4);
        check("prio_pc", 32'(im_addr), 3);

        // PC wrap: 17 NOPs in free-run
        reset = 1'b0;
        tick;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) imem[i] = 12'h400;
        run_mode = 1'b1;
        strobes = 0; wrapped = 1'b0; done = 1'b0; prev_addr = 4'd0;
        for (int i = 1; i <= 200; i++) begin
            tick;
            if (d_rd || d_wr || rf_we) strobes++;
            if (prev_addr == 4'd15 && im_addr == 4'd0) wrapped = 1'b1;
            prev_addr = im_addr;
            if (retired == 8'd16) run_mode = 1'b0;
            if (retired == 8'd17 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        run_mode = 1'b0;
        check("wrap_done", 32'(done), 1);
        check("wrap_ret", 32'(retired), 17);
        check("wrap_pc", 32'(im_addr), 1);
        check("wrap_seen", 32'(wrapped), 1);
        check("wrap_strobes", 32'(strobes), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
